alu_seq: RTL
============

# alu_seq

Sequencer and arbiter that owns the single 8-bit ALU and shares it between two requesters: requester 0 is the execute unit and requester 1 is the address/PC unit. It grants one requester at a time in round-robin order, latches that requester's operands, drives the ALU, and registers the result. It also holds the architectural flags register: the flags register feeds the ALU's flag input and is optionally updated from the ALU's flag output. It sits between the decode/execute stages and the combinational `alu`, which is instantiated beside it at CPU top level.

## Interface
Parameters:
- none (widths are fixed by the ALU: 8-bit data, 4-bit op, 8-bit flags)

Ports:
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 2: per-requester request valid
- `req_ready` out 2: per-requester accept; one-hot or zero
- `req_op` in 8: `{op1, op0}`, 4-bit ALU opcode per requester
- `req_a` in 16: `{a1, a0}`, 8-bit operand A per requester
- `req_b` in 16: `{b1, b0}`, 8-bit operand B per requester (shift count for SHR/SHL/SAR)
- `req_wr_flags` in 2: per requester, 1 = commit the ALU flags to `flags_q`
- `rsp_valid` out 1: result valid
- `rsp_ready` in 1: consumer accepts the result
- `rsp_id` out 1: requester that owns the result
- `rsp_c` out 8: registered ALU result
- `rsp_flags` out 8: registered ALU flags
- `flags_q` out 8: architectural flags register
- `flags_load` in 1: external flags write (POPF-style)
- `flags_wdata` in 8: value for the external flags write
- `alu_a`, `alu_b` out 8: ALU operands
- `alu_op` out 4: ALU opcode
- `alu_cpu_flags` out 8: driven by `flags_q`
- `alu_c` in 8: ALU result
- `alu_flags` in 8: ALU flags

## Operation
- Flags bit layout:
  - [0] carry, [1] aux_carry, [2] zero, [3] sign, [4] parity (1 = even number of ones), [5] overflow
  - [7:6] are reserved and pass through unchanged.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is set, grant one requester. With both valid, the requester selected by `rr_ptr` wins; with one valid, that one wins.
  - `req_ready[g]` is asserted combinationally in this same cycle; the handshake completes on `valid & ready`.
  - On the handshake edge: latch op/a/b/wr_flags/id into `*_q`, set `rr_ptr` to `~g`, go to EXEC.
- EXEC:
  - `alu_*` are driven from the `*_q` registers.
  - On the edge: capture `alu_c` into `rsp_c`, `alu_flags` into `rsp_flags`, `id_q` into `rsp_id`; set `rsp_valid`; go to RESP.
  - If `wr_flags_q` is set, `flags_q` takes `alu_flags` on the same edge.
- RESP:
  - `rsp_*` are held stable while `rsp_valid & ~rsp_ready`.
  - On `rsp_ready`: clear `rsp_valid`, go to IDLE.
- `req_ready` is 0 in EXEC and RESP. Only one operation is ever in flight.
- `flags_load`:
  - Writes `flags_wdata` to `flags_q` in any state.
  - If it coincides with an EXEC flag commit, `flags_load` wins.
- `alu_op`, `alu_a` and `alu_b` always reflect the `*_q` registers, in every state.

## Timing
- Handshake accepted at edge T; `rsp_valid` rises at edge T+1, i.e. it is high in the cycle after EXEC.
- Fastest case: the result is visible 2 cycles after the request cycle. With `rsp_ready` tied high, the peak rate is 1 operation per 3 cycles.
- A committed `flags_q` change becomes visible at the same edge that `rsp_valid` rises.
- Reset values: state IDLE, `rr_ptr` 0, `req_ready` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_c` 0x00, `rsp_flags` 0x00, `flags_q` 0x00, `op_q`/`a_q`/`b_q` 0.
- Reset has priority over everything. Reset asserted in EXEC or RESP aborts the operation: no response and no flag commit on that edge.
- `req_valid` dropped before its handshake: no effect, no grant recorded.

## Structure
- Shared include `alu_defs.vh`: the opcode constants (moved out of `alu` so both modules use one definition), flag bit-index constants, and FSM state encodings.
- A natural sub-module is `rr_arb2`: the 2-way round-robin grant logic plus the `rr_ptr` register.
- `alu` is not instantiated inside `alu_seq`; top level connects the `alu_*` ports to it.

## Test plan
Benches instantiate `alu_seq` together with `alu`.
- **Single AND, no flag commit:** after reset, req0 AND a=0xCA b=0xAA, `wr_flags`=0, `rsp_ready`=1. Expect `req_ready`=01 in the request cycle; `rsp_valid` 2 cycles later with `rsp_c`=0x8A and `rsp_id`=0; `flags_q` stays 0x00.
- **ADD with flag commit:** req1 ADD a=0xCA b=0xAA, `wr_flags`=1. Expect `rsp_c`=0x74, `rsp_flags[5:0]`=0x33 (OV, P, AC, C set), and `flags_q` = 0x33 on the same edge `rsp_valid` rises.
- **Round-robin:** both requesters valid continuously from reset. Expect grants 0,1,0,1 with `rsp_id` alternating; `req_ready` is never 11.
- **Response backpressure:** `rsp_ready`=0 for 5 cycles during RESP. Expect `rsp_c`/`rsp_flags`/`rsp_id` stable, `req_ready`=00 throughout, and a grant only in the cycle after `rsp_ready`=1.
- **Simultaneous flag writes:** `flags_load`=1 with `flags_wdata`=0x80 in the EXEC cycle of a `wr_flags`=1 ADD. Expect `flags_q`=0x80, while `rsp_flags` still carries the ALU flags.
- **Reset mid-operation:** `rst` pulsed in EXEC. Expect all outputs at their reset values the next cycle, no `rsp_valid`, and `flags_q`=0x00.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared ALU opcodes, flag bit indices and sequencer state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [3:0] c_OP_ADD = 4'h0;
    localparam logic [3:0] c_OP_ADC = 4'h1;
    localparam logic [3:0] c_OP_SUB = 4'h2;
    localparam logic [3:0] c_OP_AND = 4'h3;
    localparam logic [3:0] c_OP_OR  = 4'h4;
    localparam logic [3:0] c_OP_XOR = 4'h5;
    localparam logic [3:0] c_OP_SHL = 4'h6;
    localparam logic [3:0] c_OP_SHR = 4'h7;
    localparam logic [3:0] c_OP_SAR = 4'h8;

    localparam int c_FLAG_C  = 0;
    localparam int c_FLAG_AC = 1;
    localparam int c_FLAG_Z  = 2;
    localparam int c_FLAG_S  = 3;
    localparam int c_FLAG_P  = 4;
    localparam int c_FLAG_OV = 5;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Requester, response and flags-write bundle of the ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  req_wr_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [7:0]  rsp_c;
    logic [7:0]  rsp_flags;
    logic [7:0]  flags_q;
    logic        flags_load;
    logic [7:0]  flags_wdata;

    modport master (
        output req_valid, req_op, req_a, req_b, req_wr_flags,
        output rsp_ready, flags_load, flags_wdata,
        input  req_ready, rsp_valid, rsp_id, rsp_c, rsp_flags, flags_q
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_wr_flags,
        input  rsp_ready, flags_load, flags_wdata,
        output req_ready, rsp_valid, rsp_id, rsp_c, rsp_flags, flags_q
    );

endinterface : alu_seq_if
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational 8-bit ALU; bits [7:6] of the flags pass through.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_seq_pkg::*;
(
    input  wire logic [7:0] i_a,
    input  wire logic [7:0] i_b,
    input  wire logic [3:0] i_op,
    input  wire logic [7:0] i_cpu_flags,
    output logic [7:0]      o_c,
    output logic [7:0]      o_flags
);

    logic [8:0] w_wide;
    logic [4:0] w_nib;
    logic [7:0] w_res;
    logic       w_cin;
    logic       w_cy;
    logic       w_ac;
    logic       w_ov;

    always_comb begin
        w_wide = 9'd0;
        w_nib  = 5'd0;
        w_res  = i_a;
        w_cin  = 1'b0;
        w_cy   = 1'b0;
        w_ac   = 1'b0;
        w_ov   = 1'b0;
        case (i_op)
            c_OP_ADD, c_OP_ADC: begin
                w_cin  = (i_op == c_OP_ADC) ? i_cpu_flags[c_FLAG_C] : 1'b0;
                w_wide = {1'b0, i_a} + {1'b0, i_b} + {8'd0, w_cin};
                w_nib  = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'd0, w_cin};
                w_res  = w_wide[7:0];
                w_cy   = w_wide[8];
                w_ac   = w_nib[4];
                w_ov   = (i_a[7] == i_b[7]) && (w_res[7] != i_a[7]);
            end
            c_OP_SUB: begin
                w_wide = {1'b0, i_a} - {1'b0, i_b};
                w_nib  = {1'b0, i_a[3:0]} - {1'b0, i_b[3:0]};
                w_res  = w_wide[7:0];
                w_cy   = w_wide[8];
                w_ac   = w_nib[4];
                w_ov   = (i_a[7] != i_b[7]) && (w_res[7] != i_a[7]);
            end
            c_OP_AND: w_res = i_a & i_b;
            c_OP_OR:  w_res = i_a | i_b;
            c_OP_XOR: w_res = i_a ^ i_b;
            // Shifts keep the last bit shifted out in a ninth bit for carry.
            c_OP_SHL: begin
                w_wide = {1'b0, i_a} << i_b;
                w_res  = w_wide[7:0];
                w_cy   = w_wide[8];
            end
            c_OP_SHR: begin
                w_wide = {i_a, 1'b0} >> i_b;
                w_res  = w_wide[8:1];
                w_cy   = w_wide[0];
            end
            c_OP_SAR: begin
                w_wide = $signed({i_a, 1'b0}) >>> i_b;
                w_res  = w_wide[8:1];
                w_cy   = w_wide[0];
            end
            default: w_res = i_a;
        endcase
    end

    assign o_c     = w_res;
    assign o_flags = {i_cpu_flags[7:6], w_ov, ~^w_res, w_res[7], (w_res == 8'd0), w_ac, w_cy};

endmodule : alu
`default_nettype wire

// File: rtl/alu_seq_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_rr_arb2
// Description : Two-way round-robin grant with its rotating priority pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] i_req,
    input  wire logic       i_en,
    output logic [1:0]      o_gnt,
    output logic            o_gnt_id
);

    logic r_ptr;
    logic w_id;

    // The pointer only breaks ties; a lone requester always wins.
    assign w_id     = (&i_req) ? r_ptr : i_req[1];
    assign o_gnt_id = w_id;
    assign o_gnt    = (i_en && (|i_req)) ? (w_id ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (|o_gnt) begin
            r_ptr <= ~w_id;
        end
    end

endmodule : alu_seq_rr_arb2
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Round-robin sequencer sharing one ALU between two requesters,
//               owning the architectural flags register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    alu_seq_if.slave        bus,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [3:0]      alu_op,
    output logic [7:0]      alu_cpu_flags,
    input  wire logic [7:0] alu_c,
    input  wire logic [7:0] alu_flags
);

    logic [1:0] r_state;
    logic [3:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_wr_flags;
    logic       r_id;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [7:0] r_rsp_c;
    logic [7:0] r_rsp_flags;
    logic [7:0] r_flags;

    logic [1:0] w_gnt;
    logic       w_gnt_id;
    logic [3:0] w_sel_op;
    logic [7:0] w_sel_a;
    logic [7:0] w_sel_b;
    logic       w_sel_wf;

    alu_seq_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (bus.req_valid),
        .i_en     (r_state == c_S_IDLE),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id)
    );

    assign w_sel_op = w_gnt_id ? bus.req_op[7:4]  : bus.req_op[3:0];
    assign w_sel_a  = w_gnt_id ? bus.req_a[15:8]  : bus.req_a[7:0];
    assign w_sel_b  = w_gnt_id ? bus.req_b[15:8]  : bus.req_b[7:0];
    assign w_sel_wf = w_gnt_id ? bus.req_wr_flags[1] : bus.req_wr_flags[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_op        <= 4'd0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_wr_flags  <= 1'b0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_c     <= 8'd0;
            r_rsp_flags <= 8'd0;
            r_flags     <= 8'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (|w_gnt) begin
                        r_op       <= w_sel_op;
                        r_a        <= w_sel_a;
                        r_b        <= w_sel_b;
                        r_wr_flags <= w_sel_wf;
                        r_id       <= w_gnt_id;
                        r_state    <= c_S_EXEC;
                    end
                end
                c_S_EXEC: begin
                    r_rsp_c     <= alu_c;
                    r_rsp_flags <= alu_flags;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    if (r_wr_flags) begin
                        r_flags <= alu_flags;
                    end
                    r_state     <= c_S_RESP;
                end
                c_S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
            // Placed after the FSM so an external write overrides a commit.
            if (bus.flags_load) begin
                r_flags <= bus.flags_wdata;
            end
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_c     = r_rsp_c;
    assign bus.rsp_flags = r_rsp_flags;
    assign bus.flags_q   = r_flags;

    assign alu_a         = r_a;
    assign alu_b         = r_b;
    assign alu_op        = r_op;
    assign alu_cpu_flags = r_flags;

endmodule : alu_seq
`default_nettype wire
